// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL reconfiguration master.
// - Management-port word addresses of the reconfig controller registers.
// - Bit positions of the counter words written to the N, M and C registers.
// - FSM state encoding.
// - pack_counter(): builds an N/M/C counter word from its fields.
package pll_reconfig_pkg;

  // Management-port word addresses
  localparam logic [5:0] AddrMode   = 6'd0;
  localparam logic [5:0] AddrStatus = 6'd1;
  localparam logic [5:0] AddrStart  = 6'd2;
  localparam logic [5:0] AddrN      = 6'd3;
  localparam logic [5:0] AddrM      = 6'd4;
  localparam logic [5:0] AddrC      = 6'd5;

  // Counter word layout
  localparam int unsigned LoLsb     = 0;
  localparam int unsigned HiLsb     = 8;
  localparam int unsigned BitBypass = 16;
  localparam int unsigned BitOdd    = 17;
  localparam int unsigned CselLsb   = 18;

  // C0 is the only output counter this master reprograms
  localparam logic [4:0] CselC0 = 5'd0;

  // MODE=1 selects polling mode; any write to START kicks off reconfiguration
  localparam logic [31:0] ModePolling = 32'd1;
  localparam logic [31:0] StartGo     = 32'd0;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StWrMode   = 4'd1,
    StWrN      = 4'd2,
    StWrM      = 4'd3,
    StWrC0     = 4'd4,
    StWrStart  = 4'd5,
    StPollRd   = 4'd6,
    StPollGap  = 4'd7,
    StLockWait = 4'd8,
    StDone     = 4'd9
  } state_e;

  function automatic logic [31:0] pack_counter(input logic [7:0] hi,
                                               input logic [7:0] lo,
                                               input logic       bypass,
                                               input logic       odd);
    logic [31:0] w;
    w               = '0;
    w[LoLsb +: 8]   = lo;
    w[HiLsb +: 8]   = hi;
    w[BitBypass]    = bypass;
    w[BitOdd]       = odd;
    return w;
  endfunction

endpackage

// File: rtl/pll_reconfig_master_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, output resets to 0
//   d_i   - asynchronous input
//   q_o   - synchronized output, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_master.sv
// Avalon-MM master that reprograms a reconfigurable PLL through the reconfig
// controller's management port: MODE(polling) -> N -> M -> C0 -> START, then
// polls STATUS until done and waits for a stable PLL lock.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        - request handshake, fields captured on accept
//   cfg_{m,n,c0}_{hi,lo,odd}   - counter settings, cfg_n_bypass for N
//   mgmt_*                     - Avalon-MM master to the reconfig controller
//   pll_locked                 - PLL lock, asynchronous to clk
//   busy                       - request in progress
//   done, error                - one-cycle completion pulses
module pll_reconfig_master
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_m_hi,
  input  logic [7:0]  cfg_m_lo,
  input  logic        cfg_m_odd,
  input  logic [7:0]  cfg_n_hi,
  input  logic [7:0]  cfg_n_lo,
  input  logic        cfg_n_bypass,
  input  logic        cfg_n_odd,
  input  logic [7:0]  cfg_c0_hi,
  input  logic [7:0]  cfg_c0_lo,
  input  logic        cfg_c0_odd,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CntW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  // Compare against N-1 on the registered value so the decision is made in
  // the cycle that completes the Nth count.
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [31:0]     n_word_q, n_word_d;
  logic [31:0]     m_word_q, m_word_d;
  logic [31:0]     c_word_q, c_word_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic lock_sync;
  logic accept;
  logic timed;
  logic tmo_fire;
  logic poll_done;
  logic unused_rdata;

  // Only the STATUS done bit is consumed
  assign unused_rdata = ^mgmt_readdata[31:1];

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_sync)
  );

  assign cfg_ready = (state_q == StIdle);
  assign accept    = cfg_valid & cfg_ready;
  assign timed     = (state_q == StPollRd) || (state_q == StPollGap) ||
                     (state_q == StLockWait);
  assign tmo_fire  = timed && (tmo_q == TmoLast);
  assign poll_done = mgmt_readdata[0];

  // Configuration capture
  always_comb begin
    n_word_d = n_word_q;
    m_word_d = m_word_q;
    c_word_d = c_word_q;
    if (accept) begin
      n_word_d = pack_counter(cfg_n_hi, cfg_n_lo, cfg_n_bypass, cfg_n_odd);
      m_word_d = pack_counter(cfg_m_hi, cfg_m_lo, 1'b0, cfg_m_odd);
      c_word_d = pack_counter(cfg_c0_hi, cfg_c0_lo, 1'b0, cfg_c0_odd);
      c_word_d[CselLsb +: 5] = CselC0;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StWrMode;
      StWrMode:   if (!mgmt_waitrequest) state_d = StWrN;
      StWrN:      if (!mgmt_waitrequest) state_d = StWrM;
      StWrM:      if (!mgmt_waitrequest) state_d = StWrC0;
      StWrC0:     if (!mgmt_waitrequest) state_d = StWrStart;
      StWrStart:  if (!mgmt_waitrequest) state_d = StPollRd;
      StPollRd: begin
        if (tmo_fire)               state_d = StIdle;
        else if (!mgmt_waitrequest) state_d = poll_done ? StLockWait : StPollGap;
      end
      StPollGap:  state_d = tmo_fire ? StIdle : StPollRd;
      StLockWait: begin
        if (tmo_fire)                          state_d = StIdle;
        else if (lock_sync && cnt_q == CntLast) state_d = StDone;
      end
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Lock stability counter: any synchronized low restarts the count
  always_comb begin
    cnt_d = '0;
    if (state_q == StLockWait && lock_sync) cnt_d = cnt_q + CntW'(1);
  end

  // Timeout counter: runs across POLL_RD/POLL_GAP as one phase, restarts for
  // LOCK_WAIT, and sits at zero everywhere else.
  always_comb begin
    tmo_d = '0;
    if (timed && state_d != StIdle &&
        !(state_q == StPollRd && state_d == StLockWait)) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    mgmt_address   = '0;
    mgmt_read      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_writedata = '0;
    busy           = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StWrMode: begin
        mgmt_write     = 1'b1;
        mgmt_address   = AddrMode;
        mgmt_writedata = ModePolling;
      end
      StWrN: begin
        mgmt_write     = 1'b1;
        mgmt_address   = AddrN;
        mgmt_writedata = n_word_q;
      end
      StWrM: begin
        mgmt_write     = 1'b1;
        mgmt_address   = AddrM;
        mgmt_writedata = m_word_q;
      end
      StWrC0: begin
        mgmt_write     = 1'b1;
        mgmt_address   = AddrC;
        mgmt_writedata = c_word_q;
      end
      StWrStart: begin
        mgmt_write     = 1'b1;
        mgmt_address   = AddrStart;
        mgmt_writedata = StartGo;
      end
      StPollRd: begin
        mgmt_read    = 1'b1;
        mgmt_address = AddrStatus;
      end
      StPollGap:  ;
      StLockWait: ;
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
    // Error is the last cycle of the request, like DONE
    if (tmo_fire) begin
      error = 1'b1;
      busy  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_word_q <= '0;
      m_word_q <= '0;
      c_word_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_word_q <= n_word_d;
      m_word_q <= m_word_d;
      c_word_q <= c_word_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Directed bench for pll_reconfig_master with a small Avalon slave model.
module tb_pll_reconfig_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_m_hi = '0, cfg_m_lo = '0, cfg_n_hi = '0, cfg_n_lo = '0;
  logic [7:0]  cfg_c0_hi = '0, cfg_c0_lo = '0;
  logic        cfg_m_odd = 1'b0, cfg_n_bypass = 1'b0, cfg_n_odd = 1'b0, cfg_c0_odd = 1'b0;
  logic [5:0]  mgmt_address;
  logic        mgmt_read, mgmt_write;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;
  logic        busy, done, error;

  pll_reconfig_master #(
    .LOCK_STABLE_CYCLES (16),
    .TIMEOUT_CYCLES     (100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_m_hi         (cfg_m_hi),
    .cfg_m_lo         (cfg_m_lo),
    .cfg_m_odd        (cfg_m_odd),
    .cfg_n_hi         (cfg_n_hi),
    .cfg_n_lo         (cfg_n_lo),
    .cfg_n_bypass     (cfg_n_bypass),
    .cfg_n_odd        (cfg_n_odd),
    .cfg_c0_hi        (cfg_c0_hi),
    .cfg_c0_lo        (cfg_c0_lo),
    .cfg_c0_odd       (cfg_c0_odd),
    .mgmt_address     (mgmt_address),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model knobs (written by the stimulus only)
  int wait_n  = 0;   // stall cycles per transaction
  int zeros_n = 0;   // STATUS reads returning 0 before the first 1
  int rd_base = 0;

  // Slave model / monitor state (written by the monitor only)
  int          stall = 0;
  logic        prev_stalled = 1'b0;
  logic [5:0]  prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_wr;
  int          unstable = 0, overlap = 0, done_cnt = 0, err_cnt = 0, end_cyc = 0;
  logic        end_busy, end_ready;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  logic [5:0]  rd_addr[$];

  always @(negedge clk) begin
    if (mgmt_read && mgmt_write) overlap++;
    if (mgmt_read || mgmt_write) begin
      if (prev_stalled && (mgmt_address !== prev_addr || mgmt_writedata !== prev_wdata ||
                           mgmt_write !== prev_wr)) unstable++;
      mgmt_waitrequest = (stall < wait_n);
      mgmt_readdata    = {31'd0, (rd_cyc.size() - rd_base) >= zeros_n};
      if (mgmt_waitrequest) begin
        stall++;
        prev_stalled = 1'b1;
        prev_addr    = mgmt_address;
        prev_wdata   = mgmt_writedata;
        prev_wr      = mgmt_write;
      end else begin
        stall        = 0;
        prev_stalled = 1'b0;
        if (mgmt_write) begin
          wr_addr.push_back(mgmt_address);
          wr_data.push_back(mgmt_writedata);
          wr_cyc.push_back(cyc);
        end else begin
          rd_addr.push_back(mgmt_address);
          rd_cyc.push_back(cyc);
        end
      end
    end else begin
      mgmt_waitrequest = 1'b0;
      stall            = 0;
      prev_stalled     = 1'b0;
    end
    if (done || error) begin
      end_cyc   = cyc;
      end_busy  = busy;
      end_ready = cfg_ready;
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                         input logic [7:0] nh, input logic [7:0] nl, input logic nb,
                         input logic no, input logic [7:0] ch, input logic [7:0] cl,
                         input logic co, input bit keep, output int t);
    tick();
    check("ready_before_req", {31'd0, cfg_ready}, 32'd1);
    cfg_m_hi = mh; cfg_m_lo = ml; cfg_m_odd = mo;
    cfg_n_hi = nh; cfg_n_lo = nl; cfg_n_bypass = nb; cfg_n_odd = no;
    cfg_c0_hi = ch; cfg_c0_lo = cl; cfg_c0_odd = co;
    cfg_valid = 1'b1;
    t = cyc;
    tick();
    if (!keep) cfg_valid = 1'b0;
    check("busy_at_t1", {31'd0, busy}, 32'd1);
    check("wr_mode_at_t1", {25'd0, mgmt_write, mgmt_address}, {25'd0, 1'b1, 6'd0});
  endtask

  task automatic wait_read(input int n, input int max);
    int k;
    k = 0;
    while (rd_cyc.size() < rd_base + n && k < max) begin
      tick();
      k++;
    end
    check("read_within_budget", {31'd0, rd_cyc.size() >= rd_base + n}, 32'd1);
  endtask

  task automatic wait_end(input int max);
    int d0, e0, k;
    d0 = done_cnt;
    e0 = err_cnt;
    k  = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < max) begin
      tick();
      k++;
    end
    check("end_within_budget", {31'd0, (done_cnt != d0) || (err_cnt != e0)}, 32'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input logic [31:0] n_w,
                              input logic [31:0] m_w, input logic [31:0] c_w);
    logic [5:0]  ea[5];
    logic [31:0] ed[5];
    ea = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd2};
    ed = '{32'd1, n_w, m_w, c_w, 32'd0};
    check({tag, "_wr_count"}, wr_addr.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), {26'd0, wr_addr[base+i]}, {26'd0, ea[i]});
      check($sformatf("%s_wr%0d_data", tag, i), wr_data[base+i], ed[i]);
    end
  endtask

  int t, r, wb, d0, e0;

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_read", {31'd0, mgmt_read}, 32'd0);
    check("rst_write", {31'd0, mgmt_write}, 32'd0);
    check("rst_addr", {26'd0, mgmt_address}, 32'd0);
    check("rst_wdata", mgmt_writedata, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: M 4/4, N bypass, C0 2/2, no stalls; lock rises with the single read
    wb = wr_addr.size(); rd_base = rd_cyc.size(); wait_n = 0; zeros_n = 0;
    request(8'd4, 8'd4, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd2, 8'd2, 1'b0, 1'b0, t);
    wait_read(1, 20);
    pll_locked = 1'b1;
    r = rd_cyc[rd_base];
    wait_end(60);
    check_writes("t1", wb, 32'h0001_0000, 32'h0000_0404, 32'h0000_0202);
    check("t1_first_wr_cyc", wr_cyc[wb], t + 1);
    check("t1_last_wr_cyc", wr_cyc[wb+4], t + 5);
    check("t1_read_cyc", r, t + 6);
    check("t1_read_addr", {26'd0, rd_addr[rd_base]}, 32'd1);
    check("t1_read_count", rd_cyc.size() - rd_base, 32'd1);
    check("t1_done_cyc", end_cyc, r + 18);
    check("t1_done_count", done_cnt, 32'd1);
    check("t1_busy_at_done", {31'd0, end_busy}, 32'd0);
    check("t1_ready_at_done", {31'd0, end_ready}, 32'd0);
    tick();
    check("t1_ready_after", {31'd0, cfg_ready}, 32'd1);
    check("t1_done_after", {31'd0, done}, 32'd0);

    // 2: three stall cycles on every transaction, odd bits set
    wb = wr_addr.size(); rd_base = rd_cyc.size(); wait_n = 3;
    request(8'h12, 8'h34, 1'b1, 8'h03, 8'h02, 1'b0, 1'b1, 8'hAB, 8'hCD, 1'b1, 1'b0, t);
    wait_end(100);
    check_writes("t2", wb, 32'h0002_0302, 32'h0002_1234, 32'h0002_ABCD);
    check("t2_first_wr_cyc", wr_cyc[wb], t + 4);
    check("t2_last_wr_cyc", wr_cyc[wb+4], t + 20);
    check("t2_read_cyc", rd_cyc[rd_base], t + 24);
    check("t2_stable_under_stall", unstable, 32'd0);
    check("t2_done_cyc", end_cyc, t + 41);

    // 3: STATUS returns 0 three times, then 1
    tick();
    rd_base = rd_cyc.size(); wait_n = 0; zeros_n = 3;
    request(8'd1, 8'd1, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 8'd5, 8'd3, 1'b0, 1'b0, t);
    wait_end(100);
    check("t3_read_count", rd_cyc.size() - rd_base, 32'd4);
    check("t3_read0_cyc", rd_cyc[rd_base], t + 6);
    check("t3_read1_cyc", rd_cyc[rd_base+1], t + 8);
    check("t3_read3_cyc", rd_cyc[rd_base+3], t + 12);
    check("t3_done_cyc", end_cyc, t + 29);

    // 4: lock glitches low for one cycle mid-count
    tick();
    rd_base = rd_cyc.size(); zeros_n = 0;
    request(8'd3, 8'd3, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 8'd4, 8'd4, 1'b0, 1'b0, t);
    wait_read(1, 20);
    r = rd_cyc[rd_base];
    while (cyc < r + 5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_end(100);
    check("t4_done_cyc", end_cyc, r + 24);

    // 5: lock never arrives; 100-cycle lock phase times out
    pll_locked = 1'b0;
    repeat (3) tick();
    rd_base = rd_cyc.size(); d0 = done_cnt; e0 = err_cnt;
    request(8'd3, 8'd3, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 8'd4, 8'd4, 1'b0, 1'b0, t);
    wait_read(1, 20);
    r = rd_cyc[rd_base];
    wait_end(300);
    check("t5_error_count", err_cnt - e0, 32'd1);
    check("t5_error_cyc", end_cyc, r + 100);
    check("t5_no_done", done_cnt - d0, 32'd0);
    check("t5_busy_at_error", {31'd0, end_busy}, 32'd0);
    tick();
    check("t5_ready_after", {31'd0, cfg_ready}, 32'd1);
    check("t5_error_after", {31'd0, error}, 32'd0);

    // 6: reset during WR_M, then a request with cfg_valid held while busy
    pll_locked = 1'b1;
    wait_n = 3;
    request(8'd9, 8'd9, 1'b1, 8'd9, 8'd9, 1'b1, 1'b1, 8'd9, 8'd9, 1'b1, 1'b0, t);
    while (cyc < t + 10) tick();
    check("t6_in_wr_m", {25'd0, mgmt_write, mgmt_address}, {25'd0, 1'b1, 6'd4});
    rst_n = 1'b0;
    #1;
    check("t6_rst_write", {31'd0, mgmt_write}, 32'd0);
    check("t6_rst_read", {31'd0, mgmt_read}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    wait_n = 0;
    tick();
    wb = wr_addr.size(); d0 = done_cnt;
    request(8'd7, 8'd6, 1'b0, 8'd2, 8'd2, 1'b0, 1'b0, 8'd9, 8'd8, 1'b1, 1'b1, t);
    cfg_m_hi = 8'hFF; cfg_m_lo = 8'hFF; cfg_m_odd = 1'b1;
    cfg_n_hi = 8'hFF; cfg_n_lo = 8'hFF; cfg_n_bypass = 1'b1; cfg_n_odd = 1'b1;
    cfg_c0_hi = 8'hFF; cfg_c0_lo = 8'hFF; cfg_c0_odd = 1'b0;
    wait_end(100);
    cfg_valid = 1'b0;
    check_writes("t6", wb, 32'h0000_0202, 32'h0000_0706, 32'h0002_0908);
    check("t6_first_wr_cyc", wr_cyc[wb], t + 1);
    check("t6_done_count", done_cnt - d0, 32'd1);
    tick();
    tick();
    check("t6_no_second_accept", {31'd0, busy}, 32'd0);
    check("no_read_write_overlap", overlap, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
